// File: rtl/force_mem_readback.sv
// Results-RAM reader: streams entries 0..N-1 as {Z,Y,X} beats on a valid/ready interface.
// Reads are issued only when the output FIFO has room for every word already in flight.
module force_mem_readback #(
    parameter int DATA_WIDTH         = 32,
    parameter int RESULTS_ADDR_WIDTH = 14,
    parameter int RESULTS_DATA_NUM   = 10000,
    parameter int RAM_RD_LATENCY     = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_rd,
    input  logic [RESULTS_ADDR_WIDTH:0]   num_entries,
    output logic [RESULTS_ADDR_WIDTH-1:0] mem_address,
    output logic                          mem_rden,
    input  logic [3*DATA_WIDTH-1:0]       mem_q,
    output logic [DATA_WIDTH-1:0]         force_x,
    output logic [DATA_WIDTH-1:0]         force_y,
    output logic [DATA_WIDTH-1:0]         force_z,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int AW  = RESULTS_ADDR_WIDTH;
    localparam int CW  = RESULTS_ADDR_WIDTH + 1;
    localparam int L   = RAM_RD_LATENCY;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FCW = PW + 1;
    localparam int CRW = $clog2(FIFO_DEPTH + RAM_RD_LATENCY + 2) + 1;
    localparam logic [CW-1:0] MAX_N = CW'(RESULTS_DATA_NUM);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t                  state;
    logic [CW-1:0]           target;
    logic [CW-1:0]           target_in;
    logic [CW-1:0]           issued;
    logic [CW-1:0]           accepted;
    logic [AW-1:0]           rd_addr;
    logic [L-1:0]            vsr;
    logic [3*DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [FCW-1:0]          fifo_count;
    logic [CRW-1:0]          inflight;
    logic [CRW-1:0]          credit_next;
    logic                    push;
    logic                    pop;
    logic                    can_issue;

    function automatic logic [CRW-1:0] popcnt(input logic [L-1:0] v);
        logic [CRW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < RAM_RD_LATENCY; i++) begin
            n = n + CRW'(v[i]);
        end
        return n;
    endfunction

    // Occupancy after the coming edge: FIFO entries plus every read still travelling,
    // including the one on mem_rden this cycle. A new read may only take a free slot.
    always_comb begin
        push        = vsr[L-1];
        pop         = (fifo_count != '0) && out_ready;
        inflight    = popcnt(vsr);
        credit_next = CRW'(fifo_count) + inflight + CRW'(mem_rden) - CRW'(pop);
        can_issue   = credit_next < CRW'(FIFO_DEPTH);
        target_in   = (num_entries > MAX_N) ? MAX_N : num_entries;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            target      <= '0;
            issued      <= '0;
            accepted    <= '0;
            rd_addr     <= '0;
            mem_rden    <= 1'b0;
            mem_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_rden <= 1'b0;
            done     <= 1'b0;
            if (pop) begin
                accepted <= accepted + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (start_rd) begin
                        target   <= target_in;
                        accepted <= '0;
                        if (target_in == '0) begin
                            state <= FIN;
                        end else begin
                            // First read goes out together with the IDLE->READ step.
                            state       <= (target_in == CW'(1)) ? DRAIN : READ;
                            busy        <= 1'b1;
                            mem_rden    <= 1'b1;
                            mem_address <= '0;
                            rd_addr     <= AW'(1);
                            issued      <= CW'(1);
                        end
                    end
                end
                READ: begin
                    if (can_issue) begin
                        mem_rden    <= 1'b1;
                        mem_address <= rd_addr;
                        rd_addr     <= rd_addr + AW'(1);
                        issued      <= issued + CW'(1);
                        if (issued + CW'(1) == target) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accepted == target && fifo_count == '0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            vsr <= (vsr << 1) | L'(mem_rden);
            if (push && !pop) begin
                assert (fifo_count != FCW'(FIFO_DEPTH));
            end
            if (push) begin
                fifo_mem[wr_ptr] <= mem_q;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid                   = (fifo_count != '0);
    assign {force_z, force_y, force_x} = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_force_mem_readback.sv
// Directed bench for force_mem_readback with a 2-cycle RAM model holding {i+2,i+1,i} at address i.
module tb_force_mem_readback;

    localparam int DW = 32;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_rd;
    logic [AW:0]   num_entries;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic [3*DW-1:0] mem_q = '0;
    logic [DW-1:0] force_x;
    logic [DW-1:0] force_y;
    logic [DW-1:0] force_z;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    force_mem_readback #(
        .DATA_WIDTH        (DW),
        .RESULTS_ADDR_WIDTH(AW),
        .RESULTS_DATA_NUM  (10000),
        .RAM_RD_LATENCY    (2),
        .FIFO_DEPTH        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_rd   (start_rd),
        .num_entries(num_entries),
        .mem_address(mem_address),
        .mem_rden   (mem_rden),
        .mem_q      (mem_q),
        .force_x    (force_x),
        .force_y    (force_y),
        .force_z    (force_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    logic [AW-1:0] ram_a1 = '0;
    logic          ram_v1 = 1'b0;
    always @(posedge clk) begin
        ram_v1 <= mem_rden;
        ram_a1 <= mem_address;
        if (ram_v1) begin
            mem_q <= {32'(ram_a1) + 32'd2, 32'(ram_a1) + 32'd1, 32'(ram_a1)};
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt, acc_cnt, done_cnt, outstanding;
    int first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc, start_cyc, last_addr;
    int beats[$];
    logic stall_prev;
    logic [3*DW-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        if (rst) begin
            stall_prev  = 1'b0;
            outstanding = 0;
        end else begin
            if (mem_rden) begin
                rd_cnt++;
                last_addr = int'(mem_address);
                outstanding++;
                check("credit_limit", outstanding <= 4, 1);
            end
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_x", force_x, prev_data[DW-1:0]);
                check("stall_zy", {force_z, force_y}, prev_data[3*DW-1:DW]);
            end
            if (out_valid && out_ready) begin
                beats.push_back(int'(force_x));
                check("beat_zy", {force_z, force_y}, {force_x + 32'd2, force_x + 32'd1});
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                acc_cnt++;
                outstanding--;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = {force_z, force_y, force_x};
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_cnt          = 0;
        acc_cnt         = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        first_beat_cyc  = -1;
        last_beat_cyc   = -1;
        done_cyc        = -1;
        last_addr       = -1;
        beats.delete();
    endtask

    task automatic start(input int n);
        start_rd    = 1'b1;
        num_entries = 15'(n);
        tick();
        start_cyc = cyc;
        start_rd  = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        repeat (3) tick();
    endtask

    task automatic check_beats(input string tag, input int n);
        int bad;
        bad = 0;
        check({tag, "_count"}, beats.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i >= beats.size() || beats[i] != i) bad++;
        end
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1; start_rd = 1'b0; num_entries = '0; out_ready = 1'b0;
        outstanding = 0; stall_prev = 1'b0; prev_data = '0;
        clear_stats();
        repeat (2) tick();
        check("rst_rden", mem_rden, 0);
        check("rst_addr", mem_address, 0);
        check("rst_valid", out_valid, 0);
        check("rst_x", force_x, 0);
        check("rst_y", force_y, 0);
        check("rst_z", force_z, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // T1 basic
        clear_stats(); out_ready = 1'b1;
        start(8);
        check("t1_busy", busy, 1);
        run_until_done(100);
        check_beats("t1", 8);
        check("t1_latency", first_valid_cyc - start_cyc, 4);
        check("t1_b2b", last_beat_cyc - first_beat_cyc, 7);
        check("t1_reads", rd_cnt, 8);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_after", done_cyc > last_beat_cyc, 1);
        check("t1_idle_busy", busy, 0);

        // T2 backpressure
        clear_stats();
        start(16);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();
        check_beats("t2", 16);
        check("t2_reads", rd_cnt, 16);
        check("t2_done_cnt", done_cnt, 1);

        // T3 zero count and clamp
        clear_stats();
        start(0);
        run_until_done(20);
        check("t3_zero_reads", rd_cnt, 0);
        check("t3_zero_done_lat", done_cyc - start_cyc, 2);
        check("t3_zero_done_cnt", done_cnt, 1);
        clear_stats();
        start(16383);
        run_until_done(10100);
        check("t3_clamp_reads", rd_cnt, 10000);
        check("t3_clamp_last_addr", last_addr, 9999);
        check_beats("t3_clamp", 10000);
        check("t3_clamp_done_cnt", done_cnt, 1);

        // T4 start ignored while busy
        clear_stats();
        start(8);
        repeat (2) tick();
        check("t4_busy", busy, 1);
        start_rd = 1'b1; num_entries = 15'd3;
        tick();
        start_rd = 1'b0;
        run_until_done(100);
        check_beats("t4", 8);
        check("t4_reads", rd_cnt, 8);
        check("t4_done_cnt", done_cnt, 1);

        // T5 reset mid-operation
        clear_stats();
        start(16);
        for (int i = 0; i < 100 && acc_cnt < 5; i++) tick();
        check("t5_pre_beats", acc_cnt, 5);
        rst = 1'b1;
        tick();
        check("t5_rden", mem_rden, 0);
        check("t5_addr", mem_address, 0);
        check("t5_valid", out_valid, 0);
        check("t5_x", force_x, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        rst = 1'b0;
        clear_stats();
        start(4);
        run_until_done(100);
        check_beats("t5", 4);
        check("t5_reads", rd_cnt, 4);
        check("t5_done_cnt", done_cnt, 1);

        // T6 stalled from the start
        clear_stats(); out_ready = 1'b0;
        start(10);
        repeat (20) tick();
        check("t6_stall_reads", rd_cnt, 4);
        check("t6_stall_rden", mem_rden, 0);
        check("t6_stall_valid", out_valid, 1);
        check("t6_stall_head", force_x, 0);
        out_ready = 1'b1;
        run_until_done(100);
        check_beats("t6", 10);
        check("t6_reads", rd_cnt, 10);
        check("t6_done_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
